// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder: one request at a time, byte-strobed stores, full-word loads after LATENCY cycles.
// Optional DBUS_RANDOM_DELAY_EN adds 0..3 LFSR-chosen cycles of extra latency per request.
package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [4:0]            counter;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [7:0]            strobe_q;
    logic [63:0]           wdata_q;
    logic [63:0]           rdata_q;
    logic [63:0]           mem [2**DEPTH_LOG2];

    logic [1:0]            extra;
    logic [4:0]            load_cnt;
    logic [DEPTH_LOG2-1:0] idx_in;
    logic                  accept;
    logic                  acc;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [7:0]            acc_strb;
    logic [63:0]           acc_data;

`ifdef DBUS_RANDOM_DELAY_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign extra = lfsr[1:0];
`else
    assign extra = 2'd0;
`endif

    // size and the non-index address bits play no part in the access
    logic unused_bits;
    assign unused_bits = ^{dreq.size, dreq.addr[31:DEPTH_LOG2+3], dreq.addr[2:0]};

    assign load_cnt = 5'(LATENCY - 1) + {3'b000, extra};
    assign idx_in   = dreq.addr[DEPTH_LOG2+2:3];
    assign accept   = (state == IDLE) && dreq.valid;

    // The access fires on the edge that enters RESP; a zero load count means straight from IDLE
    always_comb begin
        acc      = 1'b0;
        acc_idx  = idx_q;
        acc_strb = strobe_q;
        acc_data = wdata_q;
        if (accept && load_cnt == 5'd0) begin
            acc      = 1'b1;
            acc_idx  = idx_in;
            acc_strb = dreq.strobe;
            acc_data = dreq.data;
        end else if (state == WAIT && dreq.valid && counter == 5'd1) begin
            acc = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (acc && !reset) begin
            for (int i = 0; i < 8; i++)
                if (acc_strb[i]) mem[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= 5'd0;
            idx_q    <= '0;
            strobe_q <= 8'd0;
            wdata_q  <= 64'd0;
            rdata_q  <= 64'd0;
        end else begin
            case (state)
                IDLE: if (dreq.valid) begin
                    idx_q    <= idx_in;
                    strobe_q <= dreq.strobe;
                    wdata_q  <= dreq.data;
                    counter  <= load_cnt;
                    state    <= (load_cnt == 5'd0) ? RESP : WAIT;
                end
                WAIT: begin
                    counter <= counter - 5'd1;
                    if (!dreq.valid)             state <= IDLE;
                    else if (counter == 5'd1)    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (acc) rdata_q <= (|acc_strb) ? 64'd0 : mem[acc_idx];
        end
    end

    assign dresp.addr_ok = accept;
    assign dresp.data_ok = (state == RESP);
    assign dresp.data    = rdata_q;
    assign busy          = (state != IDLE);
endmodule

// File: doc/dbus_sram_responder.md
Name: dbus_sram_responder

Overview:
- Data-bus responder (slave) for the memory stage's dbus_req_t / dbus_resp_t handshake.
- Backs the bus with an internal word-organised SRAM model.
- Accepts one request at a time and applies byte strobes on stores.
- Returns a full 64-bit word on loads after a configurable latency; byte/half/word extraction stays in the requester.
- Used as the data memory in the pipeline bench and the SoC sim top.

Parameters:
- LATENCY, 2: cycles from request acceptance to data_ok; legal range 1..15.
- DEPTH_LOG2, 12: log2 of the number of 64-bit words; default 4096 words = 32 KiB.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- dreq  input  dbus_req_t  request: valid, addr, size, strobe, data.
- dresp  output  dbus_resp_t  response: addr_ok, data_ok, data.
- busy  output  1  high in WAIT and RESP.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, counter=0, dresp.data_ok=0, dresp.addr_ok=0, dresp.data=0, busy=0. SRAM contents are not reset.
- Word index = addr[DEPTH_LOG2+2:3]. addr[2:0] and upper address bits are ignored; higher addresses alias. size is ignored; strobe alone selects bytes.
- Store: any strobe bit set. Load: strobe==0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - dresp.addr_ok = dreq.valid (combinational); this is acceptance.
  - On acceptance, latch addr, strobe and data; counter<=LATENCY-1.
  - Next state is RESP if LATENCY==1, else WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where counter==1, go to RESP and perform the access on that same edge:
    - Load: data register <= mem[idx].
    - Store: for each set strobe[i], mem[idx] byte i <= latched data byte i; data register <= 0.
  - For LATENCY==1 the access happens on the IDLE->RESP edge.
- RESP:
  - dresp.data_ok=1 for exactly one cycle; dresp.data is valid in this cycle.
  - Unconditional next state is IDLE.
  - Acceptance is at cycle t; data_ok is at cycle t+LATENCY.
- Back-to-back requests:
  - The requester holds valid until it sees data_ok.
  - A new request presented in the cycle after RESP is accepted in that IDLE cycle.
  - Minimum issue interval is LATENCY+1 cycles.
- Abort: if dreq.valid drops while in WAIT, return to IDLE next cycle. No SRAM write occurs and data_ok is not asserted.
- Request changes during WAIT (valid still high) are ignored; the latched copy is served.
- data_ok=0 outside RESP. dresp.data holds its last value outside RESP.
- Reset asserted mid-operation: immediately return to IDLE and drop data_ok. A pending store is not written.
- busy = (state != IDLE).

Optional Feature:
- Macro: DBUS_RANDOM_DELAY_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances every cycle.
  - At acceptance, extra = lfsr[1:0] (0..3) is added to the counter load.
  - data_ok then arrives at t+LATENCY+extra.
  - All other rules are unchanged, including abort, reset and access-on-entry-to-RESP.
- Undefined: fixed latency; no LFSR logic present.

Test Plan:
- Reset then idle: after reset deasserts with dreq.valid=0 for 10 cycles -> data_ok=0, addr_ok=0, busy=0 throughout.
- Store then load: LATENCY=2, store addr=0x80001000, strobe=8'hFF, data=64'h1122334455667788, accepted cycle t -> data_ok at t+2 only. Load of the same address presented at t+3 -> data_ok at t+5 with data=64'h1122334455667788.
- Partial strobe: word holds 64'h1122334455667788; store strobe=8'h0C, data=64'hAAAABBBBCCCCDDDD -> subsequent load returns 64'h11223344CCCC7788.
- Abort: load accepted at t with LATENCY=4; valid dropped at t+2 -> no data_ok through t+8, state IDLE at t+3. A store aborted the same way leaves the word unchanged.
- Latency=1 and aliasing: LATENCY=1, DEPTH_LOG2=12; store 64'hDEAD to addr 0x0 -> data_ok at t+1. Load from addr 0x8000 (aliases index 0) -> returns 64'hDEAD.
- Async reset mid-store: reset pulsed asynchronously (not at a clock edge) during WAIT -> data_ok stays 0, busy drops immediately, and a later load shows the old word contents.
